pal_cfg_serializer: RTL



---
 rtl/pal_cfg_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pal_cfg_serializer.sv
// Byte-stream to PAL serial config loader: shifts BITSTREAM_LEN bits LSB-first on cfg_clk rises, then enables the PAL.
// Latency: start -> byte_ready next cycle; accepted byte -> cfg_data next cycle, first cfg_clk rise CLK_DIV cycles later.
// Backpressure: byte_ready only in LOAD; a stalled source freezes cfg_clk low with cfg_data held.
module pal_cfg_serializer #(
    parameter int NUM_INPUTS        = 8,
    parameter int NUM_INTERM_STAGES = 11,
    parameter int NUM_OUTPUTS       = 5,
    parameter int CLK_DIV           = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       cfg_data,
    output logic       cfg_clk,
    output logic       pal_enable,
    output logic       busy,
    output logic       done
);
    localparam int BITSTREAM_LEN = 2 * NUM_INPUTS * NUM_INTERM_STAGES + NUM_INTERM_STAGES * NUM_OUTPUTS;
    localparam int CNT_W = $clog2(BITSTREAM_LEN + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(BITSTREAM_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_HIGH,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [3:0]       bit_in_byte, bit_in_byte_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic             cfg_data_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        shreg_nxt       = shreg;
        bit_cnt_nxt     = bit_cnt;
        bit_in_byte_nxt = bit_in_byte;
        div_cnt_nxt     = div_cnt;
        cfg_data_nxt    = cfg_data;
        if (abort) begin
            state_nxt       = S_IDLE;
            shreg_nxt       = '0;
            bit_cnt_nxt     = '0;
            bit_in_byte_nxt = '0;
            div_cnt_nxt     = '0;
            cfg_data_nxt    = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nxt       = S_LOAD;
                        bit_cnt_nxt     = '0;
                        bit_in_byte_nxt = '0;
                        div_cnt_nxt     = '0;
                    end
                end
                S_LOAD: begin
                    if (byte_valid) begin
                        shreg_nxt       = byte_data;
                        bit_in_byte_nxt = '0;
                        div_cnt_nxt     = '0;
                        state_nxt       = S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt_nxt = '0;
                        state_nxt   = S_HIGH;
                    end else begin
                        div_cnt_nxt = div_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt_nxt     = '0;
                        shreg_nxt       = {1'b0, shreg[7:1]};
                        bit_cnt_nxt     = bit_cnt + 1'b1;
                        bit_in_byte_nxt = bit_in_byte + 1'b1;
                        // The last byte stops at the stream length, so its padding bits never get a clock edge
                        if (bit_cnt_nxt == LEN_C) begin
                            state_nxt = S_DONE;
                        end else if (bit_in_byte_nxt == 4'd8) begin
                            state_nxt = S_LOAD;
                        end else begin
                            state_nxt = S_SETUP;
                        end
                    end else begin
                        div_cnt_nxt = div_cnt + 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
            // cfg_data only moves on entry to the low setup phase
            if (state_nxt == S_SETUP) begin
                cfg_data_nxt = shreg_nxt[0];
            end
        end
    end

    // All PAL-facing outputs come straight from flops so cfg_clk cannot glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            bit_in_byte <= '0;
            div_cnt     <= '0;
            cfg_data    <= 1'b0;
            cfg_clk     <= 1'b0;
            pal_enable  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            bit_in_byte <= bit_in_byte_nxt;
            div_cnt     <= div_cnt_nxt;
            cfg_data    <= cfg_data_nxt;
            cfg_clk     <= (state_nxt == S_HIGH);
            pal_enable  <= (state_nxt == S_DONE);
            busy        <= (state_nxt == S_LOAD) || (state_nxt == S_SETUP) || (state_nxt == S_HIGH);
            done        <= (state_nxt == S_DONE) && (state != S_DONE);
        end
    end

    assign byte_ready = (state == S_LOAD);

endmodule
